// File: rtl/dm_halt_ctrl.sv
// dm_halt_ctrl
//   Debug-mode halt/resume sequencer. Redirects the core fetch to the
//   debug-region halt or exception entry, or back to the saved resume PC,
//   using a valid/ack handshake. It also flags (sticky) any redirect that
//   has waited too long for acknowledgement.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   haltreq_i         level halt request from the debug module
//   resumereq_i       level resume request from the debug module
//   exception_i       pulse: exception raised while in debug mode
//   dpc_i[31:0]       resume PC, captured when the resume is accepted
//   core_ack_i        core accepts the current redirect
//   redirect_valid_o  redirect request to the core fetch unit
//   redirect_addr_o   redirect target PC
//   halted_o          core is in debug mode
//   running_o         core is executing normally
//   resumeack_o       one-cycle pulse on the first running cycle after resume
//   timeout_o         sticky: a redirect waited TimeoutCycles cycles unacked
module dm_halt_ctrl #(
    parameter logic [31:0] BaseAddr         = 32'd1,
    parameter logic [31:0] HaltAddress      = 32'd10,
    parameter logic [31:0] ExceptionAddress = 32'd12,
    parameter int unsigned TimeoutCycles    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        haltreq_i,
    input  logic        resumereq_i,
    input  logic        exception_i,
    input  logic [31:0] dpc_i,
    input  logic        core_ack_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_addr_o,
    output logic        halted_o,
    output logic        running_o,
    output logic        resumeack_o,
    output logic        timeout_o
);

    localparam int unsigned     CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    // 32-bit sums; any carry out is intentionally dropped.
    localparam logic [31:0] HaltTarget = BaseAddr + HaltAddress;
    localparam logic [31:0] ExcTarget  = BaseAddr + ExceptionAddress;

    typedef enum logic [2:0] {
        StRunning,
        StHaltPend,
        StHalted,
        StExcPend,
        StResumePend
    } state_t;

    state_t          state;
    logic [CntW-1:0] waitCnt;

    // All outputs are flops updated together with the state. The redirect
    // address register also serves as the captured resume PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= StRunning;
            waitCnt          <= '0;
            redirect_valid_o <= 1'b0;
            redirect_addr_o  <= '0;
            halted_o         <= 1'b0;
            running_o        <= 1'b1;
            resumeack_o      <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            resumeack_o <= 1'b0;
            case (state)
                StRunning: begin
                    // halted_o/running_o are left unchanged until the core
                    // actually accepts the halt redirect.
                    if (haltreq_i) begin
                        state            <= StHaltPend;
                        waitCnt          <= '0;
                        redirect_valid_o <= 1'b1;
                        redirect_addr_o  <= HaltTarget;
                    end
                end

                StHalted: begin
                    if (exception_i) begin
                        state            <= StExcPend;
                        waitCnt          <= '0;
                        redirect_valid_o <= 1'b1;
                        redirect_addr_o  <= ExcTarget;
                    end else if (resumereq_i) begin
                        state            <= StResumePend;
                        waitCnt          <= '0;
                        redirect_valid_o <= 1'b1;
                        redirect_addr_o  <= dpc_i;
                    end
                end

                StHaltPend, StExcPend, StResumePend: begin
                    if (core_ack_i) begin
                        redirect_valid_o <= 1'b0;
                        if (state == StResumePend) begin
                            state       <= StRunning;
                            halted_o    <= 1'b0;
                            running_o   <= 1'b1;
                            resumeack_o <= 1'b1;
                        end else begin
                            state     <= StHalted;
                            halted_o  <= 1'b1;
                            running_o <= 1'b0;
                        end
                    end else begin
                        if (waitCnt != CntMax) begin
                            waitCnt <= waitCnt + CntW'(1);
                        end
                        // Counter reaches the limit on this edge, so the
                        // flag becomes visible in the same following cycle.
                        if (waitCnt >= CntLast) begin
                            timeout_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state            <= StRunning;
                    redirect_valid_o <= 1'b0;
                    halted_o         <= 1'b0;
                    running_o        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_halt_ctrl.sv
module tb_dm_halt_ctrl;

    localparam logic [31:0] BaseB = 32'hFFFF_FFFF;
    localparam logic [31:0] HaltB = 32'd2;
    localparam logic [31:0] ExcB  = 32'd5;
    localparam int unsigned TB    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        haltreq = 1'b0;
    logic        resumereq = 1'b0;
    logic        exception = 1'b0;
    logic [31:0] dpc = '0;
    logic        ack = 1'b0;

    logic [1:0]  valid, halted, running, rack, tmo;
    logic [31:0] addr [2];

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    dm_halt_ctrl uA (
        .clk_i(clk), .rst_i(rst), .haltreq_i(haltreq), .resumereq_i(resumereq),
        .exception_i(exception), .dpc_i(dpc), .core_ack_i(ack),
        .redirect_valid_o(valid[0]), .redirect_addr_o(addr[0]), .halted_o(halted[0]),
        .running_o(running[0]), .resumeack_o(rack[0]), .timeout_o(tmo[0])
    );

    dm_halt_ctrl #(
        .BaseAddr(BaseB), .HaltAddress(HaltB), .ExceptionAddress(ExcB), .TimeoutCycles(TB)
    ) uB (
        .clk_i(clk), .rst_i(rst), .haltreq_i(haltreq), .resumereq_i(resumereq),
        .exception_i(exception), .dpc_i(dpc), .core_ack_i(ack),
        .redirect_valid_o(valid[1]), .redirect_addr_o(addr[1]), .halted_o(halted[1]),
        .running_o(running[1]), .resumeack_o(rack[1]), .timeout_o(tmo[1])
    );

    // Reference model: "in debug mode" flag plus an optional outstanding
    // redirect (target, whether it is a resume, how long it has waited).
    logic [31:0] pBase [2];
    logic [31:0] pHalt [2];
    logic [31:0] pExc [2];
    int unsigned pT [2];
    bit          mDebug [2];
    bit          mPend [2];
    bit          mIsRes [2];
    bit          mTmo [2];
    bit          mAckPulse [2];
    logic [31:0] mTarget [2];
    int unsigned mWait [2];

    task automatic modelStep(input int i);
        if (rst) begin
            mDebug[i] = 0; mPend[i] = 0; mIsRes[i] = 0; mTmo[i] = 0;
            mAckPulse[i] = 0; mTarget[i] = '0; mWait[i] = 0;
        end else begin
            mAckPulse[i] = 0;
            if (mPend[i]) begin
                if (ack) begin
                    mPend[i] = 0;
                    if (mIsRes[i]) begin
                        mDebug[i] = 0;
                        mAckPulse[i] = 1;
                    end else begin
                        mDebug[i] = 1;
                    end
                end else begin
                    mWait[i]++;
                    if (mWait[i] >= pT[i]) mTmo[i] = 1;
                end
            end else if (!mDebug[i]) begin
                if (haltreq) begin
                    mPend[i] = 1; mIsRes[i] = 0; mWait[i] = 0;
                    mTarget[i] = pBase[i] + pHalt[i];
                end
            end else begin
                if (exception) begin
                    mPend[i] = 1; mIsRes[i] = 0; mWait[i] = 0;
                    mTarget[i] = pBase[i] + pExc[i];
                end else if (resumereq) begin
                    mPend[i] = 1; mIsRes[i] = 1; mWait[i] = 0;
                    mTarget[i] = dpc;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r_, input logic h_, input logic q_, input logic e_,
                        input logic [31:0] d_, input logic a_);
        @(negedge clk);
        rst = r_; haltreq = h_; resumereq = q_; exception = e_; dpc = d_; ack = a_;
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelStep(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model u%0d valid", i), 32'(valid[i]), 32'(mPend[i]));
            check($sformatf("model u%0d addr", i), addr[i], mTarget[i]);
            check($sformatf("model u%0d halted", i), 32'(halted[i]), 32'(mDebug[i]));
            check($sformatf("model u%0d running", i), 32'(running[i]), 32'(!mDebug[i]));
            check($sformatf("model u%0d resumeack", i), 32'(rack[i]), 32'(mAckPulse[i]));
            check($sformatf("model u%0d timeout", i), 32'(tmo[i]), 32'(mTmo[i]));
        end
    endtask

    // ctl = {rst, haltreq, resumereq, exception, ack}
    // flg = {valid, halted, running, resumeack, timeout}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] dpc;
        logic [4:0]  flg;
        logic [31:0] a;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int ackPct;
        pBase[0] = 32'd1;  pHalt[0] = 32'd10; pExc[0] = 32'd12; pT[0] = 16;
        pBase[1] = BaseB;  pHalt[1] = HaltB;  pExc[1] = ExcB;   pT[1] = TB;

        vecs.push_back('{5'b10000, 32'h0,         5'b00100, 32'h0});
        vecs.push_back('{5'b01000, 32'h0,         5'b10100, 32'd11});
        vecs.push_back('{5'b01000, 32'h0,         5'b10100, 32'd11});
        vecs.push_back('{5'b00000, 32'h0,         5'b10100, 32'd11});
        vecs.push_back('{5'b00001, 32'h0,         5'b01000, 32'd11});
        vecs.push_back('{5'b00001, 32'h0,         5'b01000, 32'd11});
        vecs.push_back('{5'b00110, 32'h0,         5'b11000, 32'd13});
        vecs.push_back('{5'b00110, 32'h0,         5'b11000, 32'd13});
        vecs.push_back('{5'b00101, 32'h0,         5'b01000, 32'd13});
        vecs.push_back('{5'b00100, 32'h8000_0040, 5'b11000, 32'h8000_0040});
        vecs.push_back('{5'b00100, 32'h1234_5678, 5'b11000, 32'h8000_0040});
        vecs.push_back('{5'b01001, 32'h0,         5'b00110, 32'h8000_0040});
        vecs.push_back('{5'b01000, 32'h0,         5'b10100, 32'd11});
        vecs.push_back('{5'b00001, 32'h0,         5'b01000, 32'd11});
        vecs.push_back('{5'b00100, 32'hA5A5_0000, 5'b11000, 32'hA5A5_0000});
        vecs.push_back('{5'b10001, 32'h0,         5'b00100, 32'h0});
        vecs.push_back('{5'b00000, 32'h0,         5'b00100, 32'h0});
        vecs.push_back('{5'b11000, 32'h0,         5'b00100, 32'h0});
        vecs.push_back('{5'b01000, 32'h0,         5'b10100, 32'd11});

        foreach (vecs[n]) begin
            tick(vecs[n].ctl[4], vecs[n].ctl[3], vecs[n].ctl[2], vecs[n].ctl[1],
                 vecs[n].dpc, vecs[n].ctl[0]);
            check($sformatf("vec%0d valid", n),     32'(valid[0]),   32'(vecs[n].flg[4]));
            check($sformatf("vec%0d addr", n),      addr[0],         vecs[n].a);
            check($sformatf("vec%0d halted", n),    32'(halted[0]),  32'(vecs[n].flg[3]));
            check($sformatf("vec%0d running", n),   32'(running[0]), 32'(vecs[n].flg[2]));
            check($sformatf("vec%0d resumeack", n), 32'(rack[0]),    32'(vecs[n].flg[1]));
            check($sformatf("vec%0d timeout", n),   32'(tmo[0]),     32'(vecs[n].flg[0]));
        end

        // Wrapping base address and timeout after TimeoutCycles=4 waits.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap addr", addr[1], 32'h0000_0001);
        check("wrap valid", 32'(valid[1]), 32'd1);
        check("tmo k1", 32'(tmo[1]), 32'd0);
        for (int k = 2; k <= 10; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("tmo k%0d", k), 32'(tmo[1]), (k >= 5) ? 32'd1 : 32'd0);
            check($sformatf("tmo valid k%0d", k), 32'(valid[1]), 32'd1);
            check($sformatf("tmo A k%0d", k), 32'(tmo[0]), 32'd0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("tmo ack halted", 32'(halted[1]), 32'd1);
        check("tmo ack valid", 32'(valid[1]), 32'd0);
        check("tmo sticky", 32'(tmo[1]), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("tmo cleared by reset", 32'(tmo[1]), 32'd0);

        // Random traffic against the model with varying ack rates.
        for (int blk = 0; blk < 12; blk++) begin
            ackPct = (blk % 3 == 0) ? 50 : ((blk % 3 == 1) ? 12 : 3);
            for (int c = 0; c < 200; c++) begin
                tick($urandom_range(0, 299) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom,
                     $urandom_range(0, 99) < ackPct);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dm_halt_ctrl.md
DM_HALT_CTRL -- requirements
Module: dm_halt_ctrl

Interface
REQ-001 Parameter BaseAddr: 32-bit unsigned, default 1, debug-region base address.
REQ-002 Parameter HaltAddress: 32-bit unsigned, default 10, halt entry offset from BaseAddr.
REQ-003 Parameter ExceptionAddress: 32-bit unsigned, default 12, debug-exception entry offset from BaseAddr.
REQ-004 Parameter TimeoutCycles: int unsigned, default 16, minimum 1, unacknowledged-redirect cycles before timeout.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset; synchronous, active-high.
REQ-007 haltreq_i  input  1  level halt request from debug module.
REQ-008 resumereq_i  input  1  level resume request from debug module.
REQ-009 exception_i  input  1  single-cycle pulse: core raised an exception while in debug mode.
REQ-010 dpc_i  input  32  resume PC; sampled on HALTED->RESUME_PEND.
REQ-011 core_ack_i  input  1  core accepts the current redirect.
REQ-012 redirect_valid_o  output  1  redirect request to core fetch.
REQ-013 redirect_addr_o  output  32  redirect target PC.
REQ-014 halted_o  output  1  core is in debug mode.
REQ-015 running_o  output  1  core is executing normally.
REQ-016 resumeack_o  output  1  one-cycle pulse on resume completion.
REQ-017 timeout_o  output  1  sticky: some redirect waited TimeoutCycles cycles unacknowledged.

Function
REQ-018 FSM states: RUNNING, HALT_PEND, HALTED, EXC_PEND, RESUME_PEND; registered outputs, decoded from state and registers only.
REQ-019 RUNNING: running_o=1, halted_o=0, redirect_valid_o=0; haltreq_i=1 -> HALT_PEND next cycle; resumereq_i and exception_i ignored.
REQ-020 HALT_PEND: redirect_valid_o=1, redirect_addr_o=BaseAddr+HaltAddress; core_ack_i=1 -> HALTED next cycle.
REQ-021 HALTED: halted_o=1, running_o=0, redirect_valid_o=0; exception_i=1 -> EXC_PEND; else resumereq_i=1 -> RESUME_PEND with dpc_i captured the same edge; exception has priority over resume.
REQ-022 EXC_PEND: redirect_valid_o=1, redirect_addr_o=BaseAddr+ExceptionAddress, halted_o=1; core_ack_i=1 -> HALTED.
REQ-023 RESUME_PEND: redirect_valid_o=1, redirect_addr_o=captured dpc; halted_o=1; core_ack_i=1 -> RUNNING, resumeack_o=1 for exactly the first RUNNING cycle.
REQ-024 Address sums computed at 32 bits, modulo 2^32 (carry discarded).
REQ-025 Handshake: transfer occurs on an edge where redirect_valid_o=1 and core_ack_i=1; redirect_valid_o and redirect_addr_o hold stable until transfer; core_ack_i while redirect_valid_o=0 is ignored.
REQ-026 haltreq_i in HALT_PEND/HALTED/EXC_PEND/RESUME_PEND ignored; a haltreq_i still high in RUNNING after resume re-enters HALT_PEND after one RUNNING cycle.
REQ-027 exception_i outside HALTED ignored, including during EXC_PEND (no queueing).
REQ-028 Wait counter: cleared on entry to any pending state; increments each pending cycle without transfer, saturating at TimeoutCycles; reaching TimeoutCycles sets timeout_o on the following cycle.
REQ-029 Timeout does not abort the request; FSM stays in the pending state until transfer.
REQ-030 timeout_o cleared only by reset.

Reset
REQ-031 rst_i=1 at an edge -> state RUNNING, running_o=1, halted_o=0, redirect_valid_o=0, redirect_addr_o=0, resumeack_o=0, timeout_o=0, counter=0, captured dpc=0.
REQ-032 Reset mid-handshake (any pending state) abandons the redirect; no resumeack_o pulse produced.
REQ-033 Inputs ignored in the reset cycle; first transition possible on the first edge with rst_i=0.

Verification
REQ-034 Defaults, haltreq_i=1, ack after 2 cycles -> redirect_addr_o=11 held 3 cycles, halted_o=1 the cycle after ack.
REQ-035 HALTED, exception_i pulse with resumereq_i=1 same cycle -> EXC_PEND addr=13; after ack HALTED; next cycle RESUME_PEND.
REQ-036 HALTED, dpc_i=0x8000_0040, resumereq_i=1, dpc_i changed next cycle, ack -> addr=0x8000_0040 throughout, resumeack_o single pulse, running_o=1.
REQ-037 BaseAddr=0xFFFF_FFFF, HaltAddress=2 -> halt redirect addr=0x0000_0001.
REQ-038 TimeoutCycles=4, no ack for 10 cycles -> timeout_o=1 from cycle 5 of the pending state, redirect still valid; ack -> transition completes, timeout_o stays 1.
REQ-039 rst_i asserted in RESUME_PEND -> next cycle RUNNING, redirect_valid_o=0, resumeack_o=0.
